// File: rtl/csr_access_unit_pkg.sv
// Shared encodings for the CSR access unit: instruction op codes and FSM states.
package csr_access_unit_pkg;

   localparam logic [1:0] OP_ILL = 2'b00;
   localparam logic [1:0] OP_RW  = 2'b01;
   localparam logic [1:0] OP_RS  = 2'b10;
   localparam logic [1:0] OP_RC  = 2'b11;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_READ = 2'b01;
   localparam logic [1:0] ST_EVAL = 2'b10;
   localparam logic [1:0] ST_RESP = 2'b11;

   // Set/clear with a zero source are pure reads and must not touch the CSR.
   function automatic logic wr_intent(input logic [1:0] op, input logic src_zero);
      return (op == OP_RW) || (((op == OP_RS) || (op == OP_RC)) && !src_zero);
   endfunction

endpackage

// File: rtl/csr_alu.sv
// Combinational CSR write-data generator: replace, set bits or clear bits.
module csr_alu
   import csr_access_unit_pkg::*;
(
   input  logic [1:0]  op,
   input  logic [31:0] old_val,
   input  logic [31:0] src,
   output logic [31:0] result
);

   // Select the new CSR value for the decoded operation.
   always_comb begin
      result = 32'h0000_0000;
      case (op)
         OP_RW:   result = src;
         OP_RS:   result = old_val | src;
         OP_RC:   result = old_val & ~src;
         default: result = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/csr_access_unit.sv
// CSR read-modify-write sequencer: IDLE -> READ -> EVAL -> RESP, one access at a time.
module csr_access_unit
   import csr_access_unit_pkg::*;
(
   input  logic        clk_i,
   input  logic        resetb_i,
   input  logic        clk_en_i,
   input  logic        flush_i,
   input  logic        req_valid_i,
   input  logic [1:0]  req_op_i,
   input  logic        req_imm_i,
   input  logic [11:0] req_addr_i,
   input  logic [31:0] req_rs1_data_i,
   input  logic [4:0]  req_zimm_i,
   input  logic        req_src_zero_i,
   input  logic        req_rd_zero_i,
   output logic        req_ready_o,
   output logic        csr_rd_o,
   output logic [11:0] csr_rd_addr_o,
   input  logic [31:0] csr_rd_data_i,
   input  logic        csr_illegal_rd_i,
   input  logic        csr_illegal_wr_i,
   output logic        csr_wr_o,
   output logic [11:0] csr_wr_addr_o,
   output logic [31:0] csr_wr_data_o,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_data_o,
   output logic        rsp_exc_o
);

   logic [1:0]  state_r;
   logic [1:0]  op_r;
   logic [11:0] addr_r;
   logic [31:0] src_r;
   logic        src_zero_r;
   logic        rd_zero_r;
   logic [31:0] rsp_data_r;
   logic        rsp_exc_r;
   logic        rd_suppress_s;
   logic        wr_intent_s;
   logic        exc_s;
   logic [31:0] wr_data_s;

   csr_alu u_alu (
      .op      (op_r),
      .old_val (csr_rd_data_i),
      .src     (src_r),
      .result  (wr_data_s)
   );

   // Decode of the latched access; csr_* inputs are only meaningful in EVAL.
   always_comb begin
      rd_suppress_s = (op_r == OP_RW) && rd_zero_r;
      wr_intent_s   = wr_intent(op_r, src_zero_r);
      exc_s         = (op_r == OP_ILL) || csr_illegal_rd_i || (wr_intent_s && csr_illegal_wr_i);
   end

   assign req_ready_o   = (state_r == ST_IDLE);
   assign rsp_valid_o   = (state_r == ST_RESP);
   assign csr_rd_o      = (state_r == ST_READ) && !rd_suppress_s && clk_en_i;
   assign csr_rd_addr_o = addr_r;
   assign csr_wr_o      = (state_r == ST_EVAL) && wr_intent_s && !exc_s && clk_en_i && !flush_i;
   assign csr_wr_addr_o = addr_r;
   assign csr_wr_data_o = wr_data_s;
   assign rsp_data_o    = rsp_data_r;
   assign rsp_exc_o     = rsp_exc_r;

   // Sequencer state, request capture and registered response.
   always_ff @(posedge clk_i or negedge resetb_i) begin
      if (!resetb_i) begin
         state_r    <= ST_IDLE;
         op_r       <= OP_ILL;
         addr_r     <= 12'h000;
         src_r      <= 32'h0000_0000;
         src_zero_r <= 1'b0;
         rd_zero_r  <= 1'b0;
         rsp_data_r <= 32'h0000_0000;
         rsp_exc_r  <= 1'b0;
      end else if (clk_en_i) begin
         if (flush_i && (state_r != ST_IDLE)) begin
            state_r <= ST_IDLE;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  if (req_valid_i) begin
                     op_r       <= req_op_i;
                     addr_r     <= req_addr_i;
                     src_r      <= req_imm_i ? {27'h000_0000, req_zimm_i} : req_rs1_data_i;
                     src_zero_r <= req_src_zero_i;
                     rd_zero_r  <= req_rd_zero_i;
                     state_r    <= ST_READ;
                  end
               end
               ST_READ: state_r <= ST_EVAL;
               ST_EVAL: begin
                  rsp_data_r <= (exc_s || rd_suppress_s) ? 32'h0000_0000 : csr_rd_data_i;
                  rsp_exc_r  <= exc_s;
                  state_r    <= ST_RESP;
               end
               ST_RESP: begin
                  if (rsp_ready_i) begin
                     state_r <= ST_IDLE;
                  end
               end
               default: state_r <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
